// File: rtl/config_transactor.sv
// config_transactor
//
// Holds neuron, dendrite and synapse parameters written through a simple
// strobe interface and streams them out MSB-first on serial config chains:
// one chain per synapse row plus one neuron chain.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (clears params and outputs)
//   wr_en          parameter write strobe (ignored while busy)
//   wr_sel         target: 0 neuron, 1 dendrite, 2 synapse, 3 ignored
//   wr_row         row (dendrite/synapse only)
//   wr_col         column (neuron/dendrite) or synapse index (synapse)
//   wr_idx         parameter index within the element
//   wr_data        parameter value
//   start_neuron   pulse: stream the neuron chain
//   start_rows     pulse: stream all row chains in lockstep
//   cfg_data       serial data, bit r = row r, top bit = neuron chain
//   cfg_valid      per-chain valid qualifier for cfg_data
//   busy           high from first bit through last bit of a transfer
//   done           one-cycle pulse after the last bit
module config_transactor #(
  parameter int NUM_SYNAPSE_ROWS = 2,
  parameter int NUM_COLS         = 2,
  parameter int PARAM_WIDTH      = 8,
  localparam int ROW_W = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
  localparam int COL_W = $clog2(2 * NUM_COLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_sel,
  input  logic [ROW_W-1:0]            wr_row,
  input  logic [COL_W-1:0]            wr_col,
  input  logic [1:0]                  wr_idx,
  input  logic [PARAM_WIDTH-1:0]      wr_data,
  input  logic                        start_neuron,
  input  logic                        start_rows,
  output logic [NUM_SYNAPSE_ROWS:0]   cfg_data,
  output logic [NUM_SYNAPSE_ROWS:0]   cfg_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int NEU_LEN = 2 * NUM_COLS;   // params on the neuron chain
  localparam int ROW_LEN = 9 * NUM_COLS;   // params on each row chain
  localparam int CNT_W   = $clog2(ROW_LEN);
  localparam int BIT_W   = (PARAM_WIDTH > 1) ? $clog2(PARAM_WIDTH) : 1;
  localparam int CHAINS  = NUM_SYNAPSE_ROWS + 1;

  localparam logic [CHAINS-1:0] NEU_VALID  = CHAINS'(1) << NUM_SYNAPSE_ROWS;
  localparam logic [CHAINS-1:0] ROWS_VALID = NEU_VALID - CHAINS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_NEURON,
    SHIFT_ROWS,
    DONE
  } state_t;

  state_t                    state_reg;
  logic [CNT_W-1:0]          param_cnt_reg;
  logic [BIT_W-1:0]          bit_cnt_reg;
  logic [CHAINS-1:0]         cfg_data_reg;
  logic [CHAINS-1:0]         cfg_valid_reg;
  logic                      busy_reg;
  logic                      done_reg;

  // Parameter storage. Each row chain is stored flat in stream order:
  // column c occupies entries 9c..9c+8 = dendrite p0..2, synapse 2c p0..2,
  // synapse 2c+1 p0..2, so the shift counter addresses it directly.
  logic [PARAM_WIDTH-1:0]    neu_mem_reg [NEU_LEN];
  logic [PARAM_WIDTH-1:0]    row_mem_reg [NUM_SYNAPSE_ROWS][ROW_LEN];

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  logic                      row_ok;
  logic                      neu_wr;
  logic                      den_wr;
  logic                      syn_wr;
  logic [CNT_W-1:0]          neu_waddr;
  logic [CNT_W-1:0]          den_waddr;
  logic [CNT_W-1:0]          syn_waddr;
  logic [CNT_W-1:0]          row_waddr;

  always_comb begin
    row_ok    = int'(wr_row) < NUM_SYNAPSE_ROWS;
    neu_wr    = wr_en && !busy_reg && (wr_sel == 2'd0) &&
                (int'(wr_col) < NUM_COLS) && (wr_idx < 2'd2);
    den_wr    = wr_en && !busy_reg && (wr_sel == 2'd1) && row_ok &&
                (int'(wr_col) < NUM_COLS) && (wr_idx < 2'd3);
    syn_wr    = wr_en && !busy_reg && (wr_sel == 2'd2) && row_ok &&
                (int'(wr_col) < 2 * NUM_COLS) && (wr_idx < 2'd3);
    neu_waddr = CNT_W'(wr_col) * CNT_W'(2) + CNT_W'(wr_idx);
    den_waddr = CNT_W'(wr_col) * CNT_W'(9) + CNT_W'(wr_idx);
    // Synapse s lives in column s/2, after the 3 dendrite params, and the
    // odd synapse of the pair sits 3 entries further on.
    syn_waddr = CNT_W'(wr_col >> 1) * CNT_W'(9) + CNT_W'(3) +
                (wr_col[0] ? CNT_W'(3) : CNT_W'(0)) + CNT_W'(wr_idx);
    row_waddr = den_wr ? den_waddr : syn_waddr;
  end

  logic [NEU_LEN-1:0]                        neu_we;
  logic [NUM_SYNAPSE_ROWS-1:0][ROW_LEN-1:0]  row_we;

  genvar gi, gr;
  generate
    for (gi = 0; gi < NEU_LEN; gi++) begin : g_neu_we
      assign neu_we[gi] = neu_wr && (neu_waddr == CNT_W'(gi));
    end
    for (gr = 0; gr < NUM_SYNAPSE_ROWS; gr++) begin : g_row_we
      for (gi = 0; gi < ROW_LEN; gi++) begin : g_entry
        assign row_we[gr][gi] = (den_wr || syn_wr) &&
                                (wr_row == ROW_W'(gr)) &&
                                (row_waddr == CNT_W'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NEU_LEN; i++) begin
        neu_mem_reg[i] <= '0;
      end
      for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
        for (int i = 0; i < ROW_LEN; i++) begin
          row_mem_reg[r][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NEU_LEN; i++) begin
        if (neu_we[i]) begin
          neu_mem_reg[i] <= wr_data;
        end
      end
      for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
        for (int i = 0; i < ROW_LEN; i++) begin
          if (row_we[r][i]) begin
            row_mem_reg[r][i] <= wr_data;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stream position of the bit to be registered at the next edge
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]          param_cnt_next;
  logic [BIT_W-1:0]          bit_cnt_next;
  logic                      neu_last;
  logic                      row_last;

  always_comb begin
    param_cnt_next = param_cnt_reg;
    bit_cnt_next   = bit_cnt_reg - 1'b1;
    if (state_reg == IDLE) begin
      param_cnt_next = '0;
      bit_cnt_next   = BIT_W'(PARAM_WIDTH - 1);
    end else if (bit_cnt_reg == '0) begin
      param_cnt_next = param_cnt_reg + 1'b1;
      bit_cnt_next   = BIT_W'(PARAM_WIDTH - 1);
    end
    neu_last = (bit_cnt_reg == '0) && (param_cnt_reg == CNT_W'(NEU_LEN - 1));
    row_last = (bit_cnt_reg == '0) && (param_cnt_reg == CNT_W'(ROW_LEN - 1));
  end

  // Bit selection as a one-hot AND-OR over the stored entries.
  logic [NEU_LEN-1:0]                        neu_hit;
  logic [NUM_SYNAPSE_ROWS-1:0][ROW_LEN-1:0]  row_hit;
  logic                                      neu_bit;
  logic [NUM_SYNAPSE_ROWS-1:0]               row_bits;

  generate
    for (gi = 0; gi < NEU_LEN; gi++) begin : g_neu_hit
      assign neu_hit[gi] = (param_cnt_next == CNT_W'(gi)) &&
                           neu_mem_reg[gi][bit_cnt_next];
    end
    for (gr = 0; gr < NUM_SYNAPSE_ROWS; gr++) begin : g_row_hit
      for (gi = 0; gi < ROW_LEN; gi++) begin : g_entry
        assign row_hit[gr][gi] = (param_cnt_next == CNT_W'(gi)) &&
                                 row_mem_reg[gr][gi][bit_cnt_next];
      end
      assign row_bits[gr] = |row_hit[gr];
    end
  endgenerate

  assign neu_bit = |neu_hit;

  // ---------------------------------------------------------------------
  // Transfer state machine with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      param_cnt_reg <= '0;
      bit_cnt_reg   <= '0;
      cfg_data_reg  <= '0;
      cfg_valid_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          // start_neuron wins when both starts arrive together.
          if (start_neuron) begin
            state_reg     <= SHIFT_NEURON;
            param_cnt_reg <= param_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            cfg_valid_reg <= NEU_VALID;
            cfg_data_reg  <= {neu_bit, {NUM_SYNAPSE_ROWS{1'b0}}};
            busy_reg      <= 1'b1;
          end else if (start_rows) begin
            state_reg     <= SHIFT_ROWS;
            param_cnt_reg <= param_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            cfg_valid_reg <= ROWS_VALID;
            cfg_data_reg  <= {1'b0, row_bits};
            busy_reg      <= 1'b1;
          end
        end
        SHIFT_NEURON: begin
          if (neu_last) begin
            state_reg     <= DONE;
            cfg_valid_reg <= '0;
            cfg_data_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            param_cnt_reg <= param_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            cfg_data_reg  <= {neu_bit, {NUM_SYNAPSE_ROWS{1'b0}}};
          end
        end
        SHIFT_ROWS: begin
          if (row_last) begin
            state_reg     <= DONE;
            cfg_valid_reg <= '0;
            cfg_data_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            param_cnt_reg <= param_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            cfg_data_reg  <= {1'b0, row_bits};
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cfg_data  = cfg_data_reg;
  assign cfg_valid = cfg_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_config_transactor.sv
// tb_config_transactor
//
// Directed sequence with randomized parameter writes for config_transactor
// at default sizing (2 rows, 2 columns, 8-bit params). A parameter table
// indexed by (row, column/synapse, param) is the reference; expected serial
// streams are assembled from it in the documented chain order.
module tb_config_transactor;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int W  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic       wr_row = '0;
  logic [1:0] wr_col = '0;
  logic [1:0] wr_idx = '0;
  logic [7:0] wr_data = '0;
  logic       start_neuron = 1'b0;
  logic       start_rows = 1'b0;
  logic [2:0] cfg_data;
  logic [2:0] cfg_valid;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_neu [NC][2];
  logic [7:0] m_den [NR][NC][3];
  logic [7:0] m_syn [NR][2*NC][3];

  config_transactor dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .start_neuron (start_neuron),
    .start_rows   (start_rows),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void clear_model();
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < 2; p++) m_neu[c][p] = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < 3; p++) m_den[r][c][p] = '0;
      for (int s = 0; s < 2*NC; s++)
        for (int p = 0; p < 3; p++) m_syn[r][s][p] = '0;
    end
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, cfg_valid, cfg_data});
  endfunction

  // One write, applied at a negedge; the model keeps only in-range writes.
  task automatic wr(input int sel, input int row, input int col, input int idx,
                    input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = 2'(sel);
    wr_row  = 1'(row);
    wr_col  = 2'(col);
    wr_idx  = 2'(idx);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel == 0 && col < NC && idx < 2)
      m_neu[col][idx] = data;
    else if (sel == 1 && row < NR && col < NC && idx < 3)
      m_den[row][col][idx] = data;
    else if (sel == 2 && row < NR && col < 2*NC && idx < 3)
      m_syn[row][col][idx] = data;
  endtask

  // Runs one transfer starting at the current negedge (DUT idle) and checks
  // every cycle. poke: at bit 5 pulse both starts and a write (all must be
  // ignored). abort_at >= 0: assert reset after that bit and stop.
  task automatic do_xfer(input string tag, input bit is_neu, input bit both,
                         input bit poke, input int abort_at,
                         output logic [63:0] cap, output int busy_cnt);
    logic       eb [3][144];
    int         len;
    int         k;
    logic [7:0] ev;

    len = is_neu ? 2*NC*W : 9*NC*W;
    k = 0;
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < 2; p++)
        for (int b = W-1; b >= 0; b--) begin
          eb[2][k] = m_neu[c][p][b];
          k++;
        end
    for (int r = 0; r < NR; r++) begin
      k = 0;
      for (int c = 0; c < NC; c++) begin
        for (int p = 0; p < 3; p++)
          for (int b = W-1; b >= 0; b--) begin
            eb[r][k] = m_den[r][c][p][b];
            k++;
          end
        for (int s = 2*c; s <= 2*c+1; s++)
          for (int p = 0; p < 3; p++)
            for (int b = W-1; b >= 0; b--) begin
              eb[r][k] = m_syn[r][s][p][b];
              k++;
            end
      end
    end

    cap = '0;
    busy_cnt = 0;
    start_neuron = is_neu;
    start_rows   = both | ~is_neu;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      start_neuron = 1'b0;
      start_rows   = 1'b0;
      wr_en        = 1'b0;
      if (is_neu) ev = {1'b1, 1'b0, 3'b100, eb[2][i], 2'b00};
      else        ev = {1'b1, 1'b0, 3'b011, 1'b0, eb[1][i], eb[0][i]};
      check($sformatf("%s_bit%0d", tag, i), out_vec(), 64'(ev));
      if (busy) busy_cnt++;
      if (i < 64) cap = {cap[62:0], (is_neu ? cfg_data[2] : cfg_data[0])};
      if (poke && i == 5) begin
        start_rows   = 1'b1;
        start_neuron = 1'b1;
        wr_en        = 1'b1;
        wr_sel       = 2'($urandom_range(0, 2));
        wr_row       = 1'($urandom_range(0, 1));
        wr_col       = 2'($urandom_range(0, 1));
        wr_idx       = 2'($urandom_range(0, 1));
        wr_data      = 8'($urandom);
      end
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_abort_outputs", tag), out_vec(), 64'd0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check($sformatf("%s_idle_after_abort", tag), out_vec(), 64'd0);
        return;
      end
    end
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), out_vec(), 64'h40);
    @(negedge clk);
    check($sformatf("%s_idle", tag), out_vec(), 64'd0);
  endtask

  initial begin
    logic [63:0] cap;
    int          bc;

    clear_model();
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", out_vec(), 64'd0);

    // Neuron stream byte order
    wr(0, 0, 0, 0, 8'd1);
    wr(0, 0, 1, 0, 8'd2);
    do_xfer("neu_basic", 1'b1, 1'b0, 1'b0, -1, cap, bc);
    check("neu_bytes", 64'(cap[31:0]), 64'h01000200);
    check("neu_busy_len", 64'(bc), 64'd32);

    // Row stream byte order and length
    wr(1, 0, 0, 0, 8'hC4);
    wr(1, 0, 0, 1, 8'd10);
    wr(2, 0, 0, 0, 8'hF6);
    wr(2, 0, 0, 1, 8'h10);
    do_xfer("rows_basic", 1'b0, 1'b0, 1'b0, -1, cap, bc);
    check("row0_head", 64'(cap[63:24]), 64'hC40A00F610);
    check("rows_busy_len", 64'(bc), 64'd144);

    // Distinct row contents
    wr(2, 1, 0, 0, 8'h10);
    do_xfer("rows_distinct", 1'b0, 1'b0, 1'b0, -1, cap, bc);

    // Dropped writes, then starts and a write during busy
    wr(1, 0, 0, 3, 8'h55);
    wr(3, 1, 1, 1, 8'hAA);
    wr(0, 0, 2, 0, 8'h77);
    wr(0, 0, 0, 2, 8'h33);
    wr(1, 1, 3, 0, 8'h44);
    do_xfer("rows_dropped", 1'b0, 1'b0, 1'b1, -1, cap, bc);
    do_xfer("rows_after_busy", 1'b0, 1'b0, 1'b0, -1, cap, bc);

    // Simultaneous starts: neuron only
    do_xfer("both_starts", 1'b1, 1'b1, 1'b1, -1, cap, bc);
    do_xfer("neu_after_busy", 1'b1, 1'b0, 1'b0, -1, cap, bc);

    // Randomized contents, back-to-back transfers
    for (int t = 0; t < 3; t++) begin
      repeat (30) wr($urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
      do_xfer($sformatf("rand%0d_neu", t), 1'b1, 1'b0, 1'b0, -1, cap, bc);
      do_xfer($sformatf("rand%0d_rows", t), 1'b0, 1'b0, 1'b0, -1, cap, bc);
    end

    // Reset mid-transfer clears everything; no resume
    do_xfer("rows_abort", 1'b0, 1'b0, 1'b0, 10, cap, bc);
    repeat (3) @(negedge clk);
    check("no_resume", out_vec(), 64'd0);
    do_xfer("rows_zero", 1'b0, 1'b0, 1'b0, -1, cap, bc);
    check("rows_zero_head", cap, 64'd0);
    do_xfer("neu_zero", 1'b1, 1'b0, 1'b0, -1, cap, bc);
    check("neu_zero_bytes", 64'(cap[31:0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
